// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
`timescale 1ns/1ps
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 434;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Serial input and parallel byte/strobe outputs of the UART receiver.
`timescale 1ns/1ps
interface uart_rx_if;
    import uart_pkg::*;

    logic                 i_RX_Serial;
    logic                 o_RX_DV;
    logic [DATA_BITS-1:0] o_RX_Byte;
    logic                 o_Frame_Err;

    // The receiver is the master: it owns the byte, strobe and error outputs.
    modport master (
        input  i_RX_Serial,
        output o_RX_DV,
        output o_RX_Byte,
        output o_Frame_Err
    );

    modport slave (
        output i_RX_Serial,
        input  o_RX_DV,
        input  o_RX_Byte,
        input  o_Frame_Err
    );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
`timescale 1ns/1ps
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples each bit at its centre, timed from the detected start edge.
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.master bus
);

    localparam int             CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state, state_next;
    logic [CNT_W-1:0]     clk_cnt, clk_cnt_next;
    logic [2:0]           bit_idx, bit_idx_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic [DATA_BITS-1:0] rx_byte_next;
    logic                 rx_dv_next;
    logic                 frame_err_next;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.i_RX_Serial),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            clk_cnt         <= '0;
            bit_idx         <= '0;
            shift           <= '0;
            bus.o_RX_Byte   <= '0;
            bus.o_RX_DV     <= 1'b0;
            bus.o_Frame_Err <= 1'b0;
        end else begin
            state           <= state_next;
            clk_cnt         <= clk_cnt_next;
            bit_idx         <= bit_idx_next;
            shift           <= shift_next;
            bus.o_RX_Byte   <= rx_byte_next;
            bus.o_RX_DV     <= rx_dv_next;
            bus.o_Frame_Err <= frame_err_next;
        end
    end

    // Pulses default low so DV and frame error last exactly one clock.
    always_comb begin
        state_next     = state;
        clk_cnt_next   = clk_cnt;
        bit_idx_next   = bit_idx;
        shift_next     = shift;
        rx_byte_next   = bus.o_RX_Byte;
        rx_dv_next     = 1'b0;
        frame_err_next = 1'b0;

        unique case (state)
            IDLE: begin
                clk_cnt_next = '0;
                bit_idx_next = '0;
                if (!rx_s) state_next = START;
            end

            START: begin
                if (clk_cnt == CNT_HALF) begin
                    clk_cnt_next = '0;
                    state_next   = rx_s ? IDLE : DATA;
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end

            DATA: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_next        = '0;
                    shift_next[bit_idx] = rx_s;
                    if (bit_idx == BIT_LAST) begin
                        bit_idx_next = '0;
                        state_next   = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end

            // A low stop bit discards the byte but keeps the last good one visible.
            STOP: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_next = '0;
                    state_next   = CLEANUP;
                    if (rx_s) begin
                        rx_byte_next = shift;
                        rx_dv_next   = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end

            CLEANUP: begin
                state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: nominal, stretched start, false start, back-to-back, framing error, reset.
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CLK_NS = 20;
    localparam int CPB    = 434;
    localparam int BIT_NS = CLK_NS * CPB;

    logic clk;
    logic rst_n;

    int   checks;
    int   errors;
    int   dv_count;
    int   err_count;
    logic [7:0] rx_q[$];

    int   dv_base;
    int   err_base;
    int   q_base;

    uart_rx_if rx_bus ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rx_bus)
    );

    initial clk = 1'b0;
    always #(CLK_NS / 2) clk = ~clk;

    // Record every strobe on the falling edge, away from the register updates.
    always @(negedge clk) begin
        if (rx_bus.o_RX_DV) begin
            dv_count <= dv_count + 1;
            rx_q.push_back(rx_bus.o_RX_Byte);
        end
        if (rx_bus.o_Frame_Err) err_count <= err_count + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Caller must be on a falling edge; every delay here is a whole number of clocks.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                                 input int start_extra_ns);
        rx_bus.i_RX_Serial = 1'b0;
        #(BIT_NS + start_extra_ns);
        for (int i = 0; i < 8; i++) begin
            rx_bus.i_RX_Serial = data[i];
            #(BIT_NS);
        end
        rx_bus.i_RX_Serial = stop_bit;
        #(BIT_NS);
        rx_bus.i_RX_Serial = 1'b1;
    endtask

    task automatic markBase();
        dv_base  = dv_count;
        err_base = err_count;
        q_base   = rx_q.size();
    endtask

    initial begin
        checks             = 0;
        errors             = 0;
        dv_count           = 0;
        err_count          = 0;
        rst_n              = 1'b0;
        rx_bus.i_RX_Serial = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("reset_dv",   32'(rx_bus.o_RX_DV),     32'h0);
        checkOutput("reset_err",  32'(rx_bus.o_Frame_Err), 32'h0);
        checkOutput("reset_byte", 32'(rx_bus.o_RX_Byte),   32'h00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        markBase();
        applyStimulus(8'h37, 1'b1, 0);
        @(negedge clk);
        checkOutput("nominal_byte", 32'(rx_bus.o_RX_Byte),   32'h37);
        checkOutput("nominal_dv",   32'(dv_count - dv_base),  32'd1);
        checkOutput("nominal_err",  32'(err_count - err_base), 32'd0);

        repeat (10) @(negedge clk);
        markBase();
        applyStimulus(8'h37, 1'b1, 1000);
        @(negedge clk);
        checkOutput("stretch_dv",   32'(dv_count - dv_base),   32'd1);
        checkOutput("stretch_byte", (rx_q.size() > q_base) ? 32'(rx_q[q_base]) : 32'hDEAD, 32'h37);
        checkOutput("stretch_err",  32'(err_count - err_base), 32'd0);

        repeat (10) @(negedge clk);
        markBase();
        rx_bus.i_RX_Serial = 1'b0;
        #2000;
        rx_bus.i_RX_Serial = 1'b1;
        #(2 * BIT_NS);
        checkOutput("false_dv",    32'(dv_count - dv_base),   32'd0);
        checkOutput("false_err",   32'(err_count - err_base), 32'd0);
        checkOutput("false_byte",  32'(rx_bus.o_RX_Byte),     32'h37);
        checkOutput("false_state", 32'(dut.state),            32'(IDLE));

        markBase();
        applyStimulus(8'h00, 1'b1, 0);
        applyStimulus(8'hFF, 1'b1, 0);
        applyStimulus(8'hA5, 1'b1, 0);
        @(negedge clk);
        checkOutput("b2b_dv",  32'(dv_count - dv_base),   32'd3);
        checkOutput("b2b_err", 32'(err_count - err_base), 32'd0);
        checkOutput("b2b_b0", (rx_q.size() > q_base + 0) ? 32'(rx_q[q_base + 0]) : 32'hDEAD, 32'h00);
        checkOutput("b2b_b1", (rx_q.size() > q_base + 1) ? 32'(rx_q[q_base + 1]) : 32'hDEAD, 32'hFF);
        checkOutput("b2b_b2", (rx_q.size() > q_base + 2) ? 32'(rx_q[q_base + 2]) : 32'hDEAD, 32'hA5);

        repeat (10) @(negedge clk);
        markBase();
        applyStimulus(8'h5A, 1'b0, 0);
        @(negedge clk);
        checkOutput("ferr_err",  32'(err_count - err_base), 32'd1);
        checkOutput("ferr_dv",   32'(dv_count - dv_base),   32'd0);
        checkOutput("ferr_byte", 32'(rx_bus.o_RX_Byte),     32'hA5);

        #(2 * BIT_NS);
        markBase();
        applyStimulus(8'hC3, 1'b1, 0);
        @(negedge clk);
        checkOutput("after_ferr_dv",   32'(dv_count - dv_base),   32'd1);
        checkOutput("after_ferr_byte", 32'(rx_bus.o_RX_Byte),     32'hC3);
        checkOutput("after_ferr_err",  32'(err_count - err_base), 32'd0);

        // Abandon a frame part-way through data bit 3.
        repeat (10) @(negedge clk);
        markBase();
        rx_bus.i_RX_Serial = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 3; i++) begin
            rx_bus.i_RX_Serial = (i == 0);
            #(BIT_NS);
        end
        rx_bus.i_RX_Serial = 1'b0;
        #(BIT_NS / 2);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_mid_byte",  32'(rx_bus.o_RX_Byte),   32'h00);
        checkOutput("rst_mid_dv",    32'(rx_bus.o_RX_DV),     32'h0);
        checkOutput("rst_mid_err",   32'(rx_bus.o_Frame_Err), 32'h0);
        checkOutput("rst_mid_state", 32'(dut.state),          32'(IDLE));
        rst_n              = 1'b1;
        rx_bus.i_RX_Serial = 1'b1;
        #(2 * BIT_NS);
        checkOutput("rst_mid_no_pulse", 32'((dv_count - dv_base) + (err_count - err_base)), 32'd0);

        markBase();
        applyStimulus(8'h81, 1'b1, 0);
        @(negedge clk);
        checkOutput("post_rst_dv",   32'(dv_count - dv_base),   32'd1);
        checkOutput("post_rst_byte", 32'(rx_bus.o_RX_Byte),     32'h81);
        checkOutput("post_rst_err",  32'(err_count - err_base), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: oversampled by the system clock, LSB-first, no parity, one stop bit.
- Converts the asynchronous serial line into a parallel byte plus a one-cycle data-valid strobe.
- Sits at the serial-input edge of the design and feeds command/data consumers.
- Default timing: 50 MHz clock, 115200 baud.

Parameters:
- CLKS_PER_BIT, 434, system clocks per bit period (clk_freq / baud). Legal range ≥ 4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- i_RX_Serial  input  1  asynchronous serial line; idle high.
- o_RX_DV  output  1  one-cycle pulse: o_RX_Byte holds a newly received, correctly framed byte.
- o_RX_Byte  output  8  last correctly framed byte; held until the next valid frame.
- o_Frame_Err  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, counters=0.
  - o_RX_DV=0, o_Frame_Err=0, o_RX_Byte=8'h00.
  - Synchronizer flops preset to 1 (idle).
  - Reset mid-frame abandons the frame; no DV, no error.
- Input path: i_RX_Serial passes through a 2-flop synchronizer (rx_s). Total latency from line edge to FSM ≤ 2 clocks.
- Bit counter bit_idx (3 bits); clock counter clk_cnt (width $clog2(CLKS_PER_BIT)).
- FSM states: IDLE, START, DATA, STOP, CLEANUP.
  - IDLE: clk_cnt=0, bit_idx=0. rx_s==0 -> START.
  - START: count to (CLKS_PER_BIT-1)/2 (mid start bit).
    - rx_s still 0 -> DATA, clk_cnt=0.
    - rx_s is 1 -> IDLE (glitch/false start rejected; no output).
  - DATA: count CLKS_PER_BIT-1 clocks, then sample rx_s into shift bit bit_idx (LSB first) and clear clk_cnt.
    - After bit_idx==7 -> STOP.
    - Else bit_idx+1.
  - STOP: count CLKS_PER_BIT-1 clocks, then sample.
    - rx_s==1: o_RX_Byte <= shift register, o_RX_DV=1 for exactly one clock.
    - rx_s==0: o_Frame_Err=1 for one clock; o_RX_Byte unchanged.
    - Either way -> CLEANUP.
  - CLEANUP: one clock; deassert pulses -> IDLE.
- Start-bit handling:
  - A new start is recognized as soon as the line is low in IDLE.
  - A start bit longer than one bit period is tolerated up to ~0.5 bit extra, because all sampling is relative to the detected falling edge.
- Back-to-back frames need no idle gap beyond the stop bit: CLEANUP ends before half the stop bit elapses, for CLKS_PER_BIT ≥ 8.
- Break condition (line held low): produces a frame error, then re-arms. Each further low-line detection restarts a frame.
- o_RX_Byte and o_RX_DV are registered outputs; there is no combinational path from i_RX_Serial.

Decomposition:
- Package uart_pkg:
  - state enum typedef (IDLE, START, DATA, STOP, CLEANUP).
  - localparams DATA_BITS=8 and CLKS_PER_BIT_DEFAULT=434.
- Sub-module sync_2ff: 2-stage synchronizer with reset value parameter, instantiated for i_RX_Serial.
- The rest is one FSM module.

Test Plan:
- Nominal: clk 20 ns period, CLKS_PER_BIT=434, bit period 8680 ns. Send 0x37 (start, LSB-first data, stop) -> one o_RX_DV pulse during the stop bit. o_RX_Byte==8'h37 at the first clock after the stop bit ends. o_Frame_Err never set.
- Stretched start bit: 0x37 with the start bit lengthened by 1000 ns -> still receives 8'h37 with a single DV pulse.
- False start: line low for 2000 ns (< half bit) then high -> FSM returns to IDLE. No DV, no error, o_RX_Byte unchanged.
- Back-to-back 0x00, 0xFF, 0xA5 with no idle gap -> three DV pulses, bytes in order, no errors.
- Framing error: send 0x5A with the stop bit low -> one o_Frame_Err pulse, no DV, o_RX_Byte keeps its previous value. Next good frame 0xC3 is received.
- Reset mid-frame: assert rst_n=0 for 2 clocks during data bit 3 -> outputs zero, FSM in IDLE. Following frame 0x81 is received correctly.
